// File: rtl/axis_mixer_nch_if.sv
// AXI4-Stream bundle for axis_mixer_nch. LANES parallel streams share one
// bundle: TVALID/TLAST/TREADY are one bit per lane, TDATA packs lane i at
// [i*DATA_WIDTH +: DATA_WIDTH]. The master drives the payload and the slave
// drives TREADY.
interface axis_mixer_nch_if #(
  parameter int unsigned LANES      = 1,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [LANES-1:0]            TVALID;
  logic [LANES*DATA_WIDTH-1:0] TDATA;
  logic [LANES-1:0]            TLAST;
  logic [LANES-1:0]            TREADY;

  modport master (output TVALID, output TDATA, output TLAST, input TREADY);
  modport slave  (input TVALID, input TDATA, input TLAST, output TREADY);
endinterface

// File: rtl/axis_mixer_nch.sv
// axis_mixer_nch: N-channel stereo AXI4-Stream audio mixer.
// Each input channel buffers one left/right frame. Once every enabled channel
// holds a full frame, the gained samples of the enabled channels are summed
// and emitted as one left word followed by one right word.
// Optional feature macro: MIXER_SATURATE_EN
//   defined   - the sum is clamped to the AUDIO_WIDTH signed range and the
//               sticky CLIP flag records every clamped output word.
//   undefined - the low AUDIO_WIDTH bits are taken (wrap) and CLIP is 0.
module axis_mixer_nch #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned AUDIO_WIDTH = 24,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned GAIN_WIDTH  = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  axis_mixer_nch_if.slave                S_AXIS,
  axis_mixer_nch_if.master               M_AXIS,
  input  logic [NUM_CH-1:0]              CH_ENABLE,
  input  logic [NUM_CH*GAIN_WIDTH-1:0]   CH_GAIN,
  output logic                           CLIP,
  input  logic                           CLIP_CLR
);

  localparam int unsigned ACC_W = AUDIO_WIDTH + GAIN_WIDTH + $clog2(NUM_CH);
  localparam int unsigned PAD_W = DATA_WIDTH - AUDIO_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    SEND_L,
    SEND_R
  } state_t;

  state_t state_q, state_d;

  logic [AUDIO_WIDTH-1:0] left_q  [NUM_CH];
  logic [AUDIO_WIDTH-1:0] right_q [NUM_CH];
  logic [NUM_CH-1:0]      have_l_q;
  logic [NUM_CH-1:0]      full_q;
  logic [NUM_CH-1:0]      mix_mask_q;
  logic [NUM_CH-1:0]      s_ready;
  logic [NUM_CH-1:0]      s_hs;

  logic                   tvalid_q;
  logic                   tlast_q;
  logic [DATA_WIDTH-1:0]  tdata_q;

  logic                   start;
  logic                   load_l;
  logic                   load_r;
  logic                   release_buf;

  logic signed [ACC_W-1:0] acc_l, acc_r;
  logic [DATA_WIDTH-1:0]   word_l, word_r;
`ifdef MIXER_SATURATE_EN
  logic                    sat_l, sat_r;
  logic                    clip_q;
`endif

  // Scale one sample by an unsigned gain; unity gain is 2^(GAIN_WIDTH-1).
  function automatic logic signed [ACC_W-1:0] scale(
    input logic [AUDIO_WIDTH-1:0] smp,
    input logic [GAIN_WIDTH-1:0]  gain
  );
    logic signed [ACC_W-1:0] s_x;
    logic signed [ACC_W-1:0] g_x;
    s_x = ACC_W'($signed(smp));
    g_x = ACC_W'($signed({1'b0, gain}));
    return (s_x * g_x) >>> (GAIN_WIDTH - 1);
  endfunction

`ifdef MIXER_SATURATE_EN
  // Returns {clamped, sample}. The sum fits when every bit from the MSB down
  // to the sample sign bit agrees.
  function automatic logic [AUDIO_WIDTH:0] saturate(
    input logic signed [ACC_W-1:0] acc
  );
    logic [ACC_W-AUDIO_WIDTH:0] top;
    top = acc[ACC_W-1:AUDIO_WIDTH-1];
    if ((&top) || (~|top))
      return {1'b0, acc[AUDIO_WIDTH-1:0]};
    else if (acc[ACC_W-1])
      return {2'b11, {(AUDIO_WIDTH-1){1'b0}}};
    else
      return {2'b10, {(AUDIO_WIDTH-1){1'b1}}};
  endfunction
`endif

  assign s_ready        = {NUM_CH{ARESETN}} & (~full_q | ~CH_ENABLE);
  assign s_hs           = S_AXIS.TVALID & s_ready;
  assign S_AXIS.TREADY  = s_ready;

  assign M_AXIS.TVALID  = tvalid_q;
  assign M_AXIS.TLAST   = tlast_q;
  assign M_AXIS.TDATA   = tdata_q;

  assign start = (|CH_ENABLE) && ((full_q & CH_ENABLE) == CH_ENABLE);

  // Per-channel frame buffers: collect left then right, resync on stray words.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      have_l_q <= '0;
      full_q   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        left_q[i]  <= '0;
        right_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!CH_ENABLE[i]) begin
          have_l_q[i] <= 1'b0;
          full_q[i]   <= 1'b0;
        end else begin
          // A refill completing on the release edge keeps the new frame.
          if (release_buf && mix_mask_q[i])
            full_q[i] <= 1'b0;
          if (s_hs[i]) begin
            if (!S_AXIS.TLAST[i]) begin
              left_q[i]   <= S_AXIS.TDATA[i*DATA_WIDTH + PAD_W +: AUDIO_WIDTH];
              have_l_q[i] <= 1'b1;
            end else if (have_l_q[i]) begin
              right_q[i]  <= S_AXIS.TDATA[i*DATA_WIDTH + PAD_W +: AUDIO_WIDTH];
              full_q[i]   <= 1'b1;
              have_l_q[i] <= 1'b0;
            end
          end
        end
      end
    end
  end

  // Gain, sum and reduce both output words from the current buffers and gains.
  always_comb begin
    acc_l  = '0;
    acc_r  = '0;
    word_l = '0;
    word_r = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (CH_ENABLE[i])
        acc_l = acc_l + scale(left_q[i], CH_GAIN[i*GAIN_WIDTH +: GAIN_WIDTH]);
      if (mix_mask_q[i])
        acc_r = acc_r + scale(right_q[i], CH_GAIN[i*GAIN_WIDTH +: GAIN_WIDTH]);
    end
`ifdef MIXER_SATURATE_EN
    {sat_l, word_l[DATA_WIDTH-1 -: AUDIO_WIDTH]} = saturate(acc_l);
    {sat_r, word_r[DATA_WIDTH-1 -: AUDIO_WIDTH]} = saturate(acc_r);
`else
    word_l[DATA_WIDTH-1 -: AUDIO_WIDTH] = acc_l[AUDIO_WIDTH-1:0];
    word_r[DATA_WIDTH-1 -: AUDIO_WIDTH] = acc_r[AUDIO_WIDTH-1:0];
`endif
  end

  // Output sequencer state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Output sequencer next state and load strobes.
  always_comb begin
    state_d     = state_q;
    load_l      = 1'b0;
    load_r      = 1'b0;
    release_buf = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_l  = 1'b1;
          state_d = SEND_L;
        end
      end
      SEND_L: begin
        if (M_AXIS.TREADY[0]) begin
          load_r  = 1'b1;
          state_d = SEND_R;
        end
      end
      SEND_R: begin
        if (M_AXIS.TREADY[0]) begin
          release_buf = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered master stream outputs and the latched mix mask.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      mix_mask_q <= '0;
    end else begin
      if (load_l) begin
        tvalid_q   <= 1'b1;
        tlast_q    <= 1'b0;
        tdata_q    <= word_l;
        mix_mask_q <= CH_ENABLE;
      end
      if (load_r) begin
        tlast_q <= 1'b1;
        tdata_q <= word_r;
      end
      if (release_buf) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
    end
  end

`ifdef MIXER_SATURATE_EN
  // Sticky clip flag; a new clamp wins over a simultaneous clear.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)
      clip_q <= 1'b0;
    else if ((load_l && sat_l) || (load_r && sat_r))
      clip_q <= 1'b1;
    else if (CLIP_CLR)
      clip_q <= 1'b0;
  end

  assign CLIP = clip_q;
`else
  assign CLIP = 1'b0;
`endif

endmodule

// File: tb/tb_axis_mixer_nch.sv
// Self-checking bench for axis_mixer_nch (NUM_CH=4, 24-bit audio, 8-bit gain).
// Expected words come from a frame-level arithmetic model of the mix.
module tb_axis_mixer_nch;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned AW     = 24;
  localparam int unsigned DW     = 32;
  localparam int unsigned GW     = 8;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [3:0]  ch_enable = '0;
  logic [31:0] ch_gain = '0;
  logic        clip;
  logic        clip_clr = 1'b0;

  axis_mixer_nch_if #(.LANES(NUM_CH), .DATA_WIDTH(DW)) s_if ();
  axis_mixer_nch_if #(.LANES(1),      .DATA_WIDTH(DW)) m_if ();

  axis_mixer_nch #(
    .NUM_CH(NUM_CH), .AUDIO_WIDTH(AW), .DATA_WIDTH(DW), .GAIN_WIDTH(GW)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .S_AXIS(s_if), .M_AXIS(m_if),
    .CH_ENABLE(ch_enable), .CH_GAIN(ch_gain), .CLIP(clip), .CLIP_CLR(clip_clr)
  );

  always #5 ACLK = ~ACLK;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame under test
  logic [3:0]  fr_en;
  logic [23:0] fr_l [4];
  logic [23:0] fr_r [4];
  logic [7:0]  fr_g [4];
  bit          model_clip = 0;
  logic [31:0] last_l, last_r;

  function automatic logic [31:0] model_word(input bit right, output bit sat);
    longint acc = 0;
    longint s;
    logic [63:0] a;
    sat = 0;
    for (int i = 0; i < 4; i++) begin
      if (fr_en[i]) begin
        s = right ? longint'($signed(fr_r[i])) : longint'($signed(fr_l[i]));
        acc += (s * longint'(fr_g[i])) >>> 7;
      end
    end
`ifdef MIXER_SATURATE_EN
    if (acc > 64'sd8388607) begin acc = 64'sd8388607; sat = 1; end
    else if (acc < -64'sd8388608) begin acc = -64'sd8388608; sat = 1; end
`endif
    a = acc;
    return {a[23:0], 8'h00};
  endfunction

  // Downstream ready: random or forced
  bit rnd_rdy = 0;
  bit force_rdy = 1;
  always @(posedge ACLK) begin
    #1;
    m_if.TREADY = rnd_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
  end

  // Output monitor: collects accepted words, checks hold stability
  logic [32:0] outq [$];
  bit          stalled = 0;
  logic [32:0] held;
  always @(negedge ACLK) begin
    if (ARESETN && m_if.TVALID === 1'b1) begin
      if (stalled) check_eq("hold_stable", {m_if.TDATA, m_if.TLAST}, held);
      if (m_if.TREADY[0] === 1'b1) outq.push_back({m_if.TDATA, m_if.TLAST});
      stalled = (m_if.TREADY[0] !== 1'b1);
      held    = {m_if.TDATA, m_if.TLAST};
    end else begin
      stalled = 0;
    end
  end

  task automatic apply_cfg();
    ch_enable = fr_en;
    ch_gain   = {fr_g[3], fr_g[2], fr_g[1], fr_g[0]};
  endtask

  task automatic send_word(input int ch, input logic [23:0] smp, input bit last);
    bit ok = 0;
    @(posedge ACLK); #1;
    s_if.TVALID[ch] = 1'b1;
    s_if.TDATA[ch*32 +: 32] = {smp, 8'($urandom)};
    s_if.TLAST[ch] = last;
    for (int c = 0; c < 200; c++) begin
      @(negedge ACLK);
      if (s_if.TREADY[ch] === 1'b1) begin ok = 1; break; end
    end
    if (ok) @(posedge ACLK);
    #1;
    s_if.TVALID[ch] = 1'b0;
    check_eq("s_accept", ok, 1);
  endtask

  task automatic fill_frame(input logic [3:0] send_mask, input bit junk);
    for (int ch = 0; ch < 4; ch++) begin
      if (send_mask[ch]) begin
        if (junk && $urandom_range(0, 2) == 0) send_word(ch, 24'($urandom), 1'b1);
        if (junk && $urandom_range(0, 2) == 0) send_word(ch, 24'($urandom), 1'b0);
        send_word(ch, fr_l[ch], 1'b0);
        send_word(ch, fr_r[ch], 1'b1);
      end else if (junk && !fr_en[ch]) begin
        send_word(ch, 24'($urandom), 1'($urandom_range(0, 1)));
      end
    end
  endtask

  task automatic expect_frame();
    logic [31:0] exp_l, exp_r;
    logic [32:0] w;
    bit sl, sr;
    bit got = 0;
    exp_l = model_word(0, sl);
    exp_r = model_word(1, sr);
    for (int c = 0; c < 400; c++) begin
      @(negedge ACLK); #1;
      if (outq.size() >= 2) begin got = 1; break; end
    end
    check_eq("frame_arrived", got, 1);
    if (got) begin
      w = outq.pop_front();
      last_l = w[32:1];
      check_eq("left_data", w[32:1], exp_l);
      check_eq("left_last", w[0], 0);
      w = outq.pop_front();
      last_r = w[32:1];
      check_eq("right_data", w[32:1], exp_r);
      check_eq("right_last", w[0], 1);
      model_clip = model_clip | sl | sr;
      @(negedge ACLK);
      check_eq("release_ready", s_if.TREADY & fr_en, fr_en);
      check_eq("clip", clip, model_clip);
    end
  endtask

  task automatic wait_tvalid();
    for (int c = 0; c < 100; c++) begin
      @(negedge ACLK);
      if (m_if.TVALID === 1'b1) break;
    end
    check_eq("tvalid_rise", m_if.TVALID, 1);
  endtask

  task automatic set_unity(input logic [3:0] en);
    fr_en = en;
    for (int i = 0; i < 4; i++) begin
      fr_g[i] = 8'h80;
      fr_l[i] = '0;
      fr_r[i] = '0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap;
    s_if.TVALID = '0;
    s_if.TDATA  = '0;
    s_if.TLAST  = '0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_eq("rst_tvalid", m_if.TVALID, 0);
    check_eq("rst_tlast", m_if.TLAST, 0);
    check_eq("rst_tdata", m_if.TDATA, 0);
    check_eq("rst_clip", clip, 0);
    check_eq("rst_s_ready", s_if.TREADY, 4'h0);
    ARESETN = 1'b1;
    #1 check_eq("idle_s_ready", s_if.TREADY, 4'hF);

    // Two channels at unity gain
    set_unity(4'b0011);
    fr_l[0] = 24'h100000; fr_r[0] = 24'h000010;
    fr_l[1] = 24'h200000; fr_r[1] = 24'h000020;
    apply_cfg(); fill_frame(fr_en, 0); expect_frame();
    check_eq("tp_sum_l", last_l, 32'h30000000);
    check_eq("tp_sum_r", last_r, 32'h00003000);

    // Positive overflow
    set_unity(4'b0011);
    fr_l[0] = 24'h7FFFFF; fr_l[1] = 24'h000001;
    apply_cfg(); fill_frame(fr_en, 0); expect_frame();
`ifdef MIXER_SATURATE_EN
    check_eq("tp_ovf_l", last_l, 32'h7FFFFF00);
    check_eq("tp_ovf_clip", clip, 1);
`else
    check_eq("tp_ovf_l", last_l, 32'h80000000);
    check_eq("tp_ovf_clip", clip, 0);
`endif
    @(posedge ACLK); #1 clip_clr = 1'b1;
    @(posedge ACLK); #1 clip_clr = 1'b0;
    model_clip = 0;
    check_eq("clip_clr", clip, 0);

    // Half gain, positive and negative
    set_unity(4'b0001);
    fr_g[0] = 8'h40; fr_l[0] = 24'h200000; fr_r[0] = 24'hFFFFF0;
    apply_cfg(); fill_frame(fr_en, 0); expect_frame();
    check_eq("tp_half_l", last_l, 32'h10000000);
    check_eq("tp_half_r", last_r, 32'hFFFFF800);

    // Backpressure: output held, channel buffer not released
    set_unity(4'b0001);
    fr_l[0] = 24'($urandom); fr_r[0] = 24'($urandom);
    force_rdy = 0;
    apply_cfg(); fill_frame(fr_en, 0);
    wait_tvalid();
    snap = m_if.TDATA;
    for (int k = 0; k < 10; k++) begin
      @(negedge ACLK);
      check_eq("stall_tvalid", m_if.TVALID, 1);
      check_eq("stall_tdata", m_if.TDATA, snap);
      check_eq("stall_s_ready", s_if.TREADY[0], 0);
    end
    force_rdy = 1;
    expect_frame();

    // Leading right word is dropped
    set_unity(4'b0100);
    fr_l[2] = 24'h000100; fr_r[2] = 24'h000200;
    apply_cfg();
    send_word(2, 24'h5A5A5A, 1'b1);
    fill_frame(fr_en, 0); expect_frame();
    check_eq("tp_resync_l", last_l, 32'h00010000);
    check_eq("tp_resync_r", last_r, 32'h00020000);

    // No enabled channel: nothing comes out
    set_unity(4'b0000);
    apply_cfg();
    for (int ch = 0; ch < 4; ch++) send_word(ch, 24'($urandom), 1'($urandom_range(0, 1)));
    repeat (20) @(negedge ACLK);
    check_eq("none_enabled", outq.size(), 0);

    // Reset while the left word is stalled
    set_unity(4'b0011);
    for (int i = 0; i < 2; i++) begin fr_l[i] = 24'($urandom); fr_r[i] = 24'($urandom); end
    force_rdy = 0;
    apply_cfg(); fill_frame(fr_en, 0);
    wait_tvalid();
    #2 ARESETN = 1'b0;
    #1;
    check_eq("arst_tvalid", m_if.TVALID, 0);
    check_eq("arst_s_ready", s_if.TREADY, 4'h0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    outq.delete();
    model_clip = 0;
    force_rdy = 1;
    for (int i = 0; i < 2; i++) begin fr_l[i] = 24'($urandom); fr_r[i] = 24'($urandom); end
    fill_frame(4'b0001, 0);
    repeat (20) @(negedge ACLK);
    check_eq("no_partial", outq.size(), 0);
    fill_frame(4'b0010, 0);
    expect_frame();

    // Randomized frames
    rnd_rdy = 1;
    for (int f = 0; f < 40; f++) begin
      fr_en = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        fr_g[i] = 8'($urandom);
        fr_l[i] = $urandom_range(0, 1) ? 24'($urandom) : 24'($urandom_range(0, 4095));
        fr_r[i] = $urandom_range(0, 1) ? 24'($urandom) : 24'($urandom_range(0, 4095));
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge ACLK); #1 clip_clr = 1'b1;
        @(posedge ACLK); #1 clip_clr = 1'b0;
        model_clip = 0;
      end
      apply_cfg();
      fill_frame(fr_en, 1);
      expect_frame();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axis_mixer_nch.md
# axis_mixer_nch

N-channel stereo AXI4-Stream audio mixer: the parametrised successor to the two-channel codec mixer. It buffers one stereo frame per input channel and applies a per-channel gain to each. It then sums signed samples across enabled channels and emits one left/right frame on the master stream toward the codec. It sits between the per-channel stream sources (network jitter buffers, local ADC path) and the codec I2S transmitter, in a single clock domain.

## Interface
- NUM_CH, 4: number of input channels (2..16).
- AUDIO_WIDTH, 24: signed two's-complement sample width.
- DATA_WIDTH, 32: stream word width; sample is MSB-justified in bits [DATA_WIDTH-1 -: AUDIO_WIDTH], lower bits zero on output, ignored on input.
- GAIN_WIDTH, 8: unsigned gain width; unity = 2^(GAIN_WIDTH-1).

- ACLK  in  1  clock.
- ARESETN  in  1  reset, asynchronous, active-low.
- S_AXIS_TVALID  in  NUM_CH  per-channel valid.
- S_AXIS_TDATA  in  NUM_CH*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- S_AXIS_TLAST  in  NUM_CH  0 = left word, 1 = right word.
- S_AXIS_TREADY  out  NUM_CH  per-channel ready.
- CH_ENABLE  in  NUM_CH  channel participates in mix.
- CH_GAIN  in  NUM_CH*GAIN_WIDTH  channel i gain at [i*GAIN_WIDTH +: GAIN_WIDTH].
- M_AXIS_TVALID  out  1  mixed word valid.
- M_AXIS_TDATA  out  DATA_WIDTH  mixed sample.
- M_AXIS_TLAST  out  1  0 = left, 1 = right.
- M_AXIS_TREADY  in  1  downstream ready.
- CLIP  out  1  sticky saturation flag.
- CLIP_CLR  in  1  synchronous clear of CLIP.

## Operation
- Per-channel frame buffer: left reg, right reg, `have_l`, `full`.
- S_AXIS_TREADY[i] = ARESETN & (~full[i] | ~CH_ENABLE[i]).
- Enabled channel, handshake with TLAST=0: store left, set have_l.
- Enabled channel, handshake with TLAST=1 and have_l: store right, set full, clear have_l.
- Enabled channel, TLAST=1 without have_l: word dropped (resync).
- Enabled channel, second TLAST=0 while have_l: overwrites left.
- Disabled channel: words accepted and discarded; have_l and full cleared.
- FSM states:
  - IDLE: go to SEND_L when at least one channel is enabled and every enabled channel is full. Latch CH_ENABLE into `mix_mask`. Register the mixed left word; TVALID=1, TLAST=0.
  - SEND_L: on M_AXIS_TREADY, register the mixed right word, TLAST=1, go to SEND_R.
  - SEND_R: on M_AXIS_TREADY, TVALID=0, clear full[] of channels in mix_mask, go to IDLE.
- No enabled channel: no output frames.
- Gain per channel: p_i = sample_i * {0,gain_i}, signed, then arithmetic shift right by GAIN_WIDTH-1.
- Accumulator width AUDIO_WIDTH+GAIN_WIDTH+clog2(NUM_CH); sum over mix_mask only.
- Output reduction to AUDIO_WIDTH: see Configuration.
- CLIP: set on any saturated output word; cleared by CLIP_CLR; set wins over a simultaneous clear.

## Timing
- Reset (async): M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, CLIP=0, all buffers empty, FSM IDLE, S_AXIS_TREADY=0 while ARESETN low.
- Reset mid-frame aborts the frame; no partial frame is emitted after release.
- Latency: full set at edge E → TVALID high after edge E+1.
- TDATA and TLAST are held stable while TVALID & ~TREADY.
- Back-to-back words: TREADY high in SEND_L gives the right word on the next cycle; no bubble between L and R.
- Buffers release at the SEND_R handshake edge; TREADY of those channels is high the following cycle.
- Minimum frame period: 5 cycles per channel refill when sources stream continuously.
- CH_ENABLE and CH_GAIN changes take effect at the next IDLE→SEND_L decision. Gain is sampled when each word is registered.

## Configuration
- MIXER_SATURATE_EN defined: the accumulator is clamped to [-2^(AUDIO_WIDTH-1), 2^(AUDIO_WIDTH-1)-1] and CLIP is set on clamp.
- Not defined: the low AUDIO_WIDTH bits are taken (two's-complement wrap), and CLIP is tied 0.

## Test plan
- NUM_CH=4, ch0/ch1 enabled, gain 0x80. ch0 L/R=0x100000/0x000010, ch1 L/R=0x200000/0x000020 → TDATA 0x30000000 (TLAST=0), then 0x00003000 (TLAST=1).
- ch0 L=0x7FFFFF, ch1 L=0x000001, unity gain → 0x7FFFFF00 and CLIP=1 with macro; 0x80000000 and CLIP=0 without.
- ch0 gain 0x40, L=0x200000 → 0x10000000. L=0xFFFFF0 (−16) → 0xFFFFF800.
- Hold M_AXIS_TREADY=0 for 10 cycles after TVALID → TDATA/TLAST stable. Channel TREADY stays 0 until the right-word handshake.
- ch2 sends TLAST=1 first, then L=0x000100, R=0x000200 → leading word dropped, frame mixes 0x000100/0x000200.
- Assert ARESETN=0 in SEND_L → TVALID drops immediately. After release, the next frame needs fresh input on all enabled channels.
